aurora_rx_lane_block_sync: RTL

// Single-lane Aurora 64b/66b receive front end for the DAQ/sim side: inverse of the Scrambler + Gearbox66to20 TX path.

---
 rtl/aurora_rx_lane_block_sync.sv | 127 ++++++++++++
 1 files changed

// File: rtl/aurora_rx_lane_block_sync.sv
// aurora_rx_lane_block_sync: 20->66 gearbox with bit-slip alignment, sync-header lock FSM and 64b/66b descrambler
module aurora_rx_lane_block_sync #(
  parameter int LOCK_GOOD  = 64,
  parameter int UNLOCK_BAD = 16,
  parameter int WINDOW     = 64,
  parameter int SLIP_WAIT  = 2
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [19:0] Data20,
  input  logic        Data20Valid,
  output logic [63:0] BlockData,
  output logic [1:0]  BlockHeader,
  output logic        BlockValid,
  output logic        Locked,
  output logic [15:0] HeaderErrCnt
);
  typedef enum logic [1:0] {SEARCH, SLIP, LOCKED} state_t;
  state_t st_q, st_d;
  logic [127:0] sr_q, sr_d, sh, xt;
  logic [7:0] fill_q, fill_d, f1;
  logic [65:0] blk_q, blk_d;
  logic blk_v_q, blk_v_d, slip_done_q, slip_done_d, val_q, val_d, lock_q, lock_d;
  logic [63:0] hist_q, hist_d, data_q, data_d, cur;
  logic [1:0] hdr_q, hdr_d, hdr;
  logic [15:0] good_q, good_d, bad_q, bad_d, win_q, win_d, skip_q, skip_d, err_q, err_d, bad_n;
  logic slip, ext, hv, wrap;
  assign BlockData    = data_q;
  assign BlockHeader  = hdr_q;
  assign BlockValid   = val_q;
  assign Locked       = lock_q;
  assign HeaderErrCnt = err_q;
  always_comb begin
    slip = st_q == SLIP && !slip_done_q && fill_q != 8'd0;
    ext = !slip && fill_q >= 8'd66;
    sh = slip ? sr_q >> 1 : ext ? sr_q >> 66 : sr_q;
    f1 = fill_q - (slip ? 8'd1 : ext ? 8'd66 : 8'd0);
    sr_d = Data20Valid ? sh | (128'(Data20) << f1) : sh;
    fill_d = f1 + (Data20Valid ? 8'd20 : 8'd0);
    blk_d = ext ? sr_q[65:0] : blk_q;
    blk_v_d = ext;
    hdr = {blk_q[0], blk_q[1]};
    cur = blk_q[65:2];
    xt = {cur, hist_q};
    hv = hdr[0] ^ hdr[1];
    wrap = win_q == 16'(WINDOW - 1);
    bad_n = (wrap ? 16'd0 : bad_q) + {15'd0, !hv};
    hist_d = blk_v_q ? cur : hist_q;
    data_d = blk_v_q ? cur ^ xt[88:25] ^ xt[69:6] : data_q;
    hdr_d = blk_v_q ? hdr : hdr_q;
    st_d = st_q;
    good_d = good_q;
    bad_d = bad_q;
    win_d = win_q;
    skip_d = skip_q;
    err_d = err_q;
    lock_d = lock_q;
    slip_done_d = slip_done_q || slip;
    case (st_q)
      SEARCH: if (blk_v_q) begin
        if (!hv) begin
          good_d = 16'd0;
          skip_d = 16'd0;
          slip_done_d = 1'b0;
          st_d = SLIP;
        end else if (good_q + 16'd1 == 16'(LOCK_GOOD)) begin
          good_d = 16'd0;
          bad_d = 16'd0;
          win_d = 16'd0;
          lock_d = 1'b1;
          st_d = LOCKED;
        end else good_d = good_q + 16'd1;
      end
      SLIP: if (slip_done_q && skip_q == 16'(SLIP_WAIT)) st_d = SEARCH;
      else if (slip_done_q && blk_v_q) skip_d = skip_q + 16'd1;
      default: if (blk_v_q) begin
        win_d = wrap ? 16'd0 : win_q + 16'd1;
        err_d = (!hv && err_q != 16'hFFFF) ? err_q + 16'd1 : err_q;
        bad_d = bad_n;
        if (bad_n == 16'(UNLOCK_BAD)) begin
          good_d = 16'd0;
          bad_d = 16'd0;
          win_d = 16'd0;
          lock_d = 1'b0;
          st_d = SEARCH;
        end
      end
    endcase
    val_d = blk_v_q && lock_d;
  end
  always_ff @(posedge Clk or negedge Rst)
    if (!Rst) begin
      st_q <= SEARCH;
      sr_q <= '0;
      fill_q <= '0;
      blk_q <= '0;
      blk_v_q <= 1'b0;
      slip_done_q <= 1'b0;
      hist_q <= '0;
      data_q <= '0;
      hdr_q <= '0;
      val_q <= 1'b0;
      lock_q <= 1'b0;
      good_q <= '0;
      bad_q <= '0;
      win_q <= '0;
      skip_q <= '0;
      err_q <= '0;
    end else begin
      st_q <= st_d;
      sr_q <= sr_d;
      fill_q <= fill_d;
      blk_q <= blk_d;
      blk_v_q <= blk_v_d;
      slip_done_q <= slip_done_d;
      hist_q <= hist_d;
      data_q <= data_d;
      hdr_q <= hdr_d;
      val_q <= val_d;
      lock_q <= lock_d;
      good_q <= good_d;
      bad_q <= bad_d;
      win_q <= win_d;
      skip_q <= skip_d;
      err_q <= err_d;
    end
endmodule
